// File: rtl/maverickone_issue_window.sv
// maverickOne issue window: compacting age-ordered queue between decode and
// execute. Each cycle it offers the oldest entry that is free of register
// locks, of footprint overlap with older waiting entries, and of blocking
// barriers. Slot 0 always holds the oldest instruction.
module maverickone_issue_window #(
   parameter int DEPTH = 4,
   parameter int NR    = 32,
   parameter int RW    = 5,
   parameter int PW    = 64
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         clear_i,
   input  logic [PW-1:0]                in_payload_i,
   input  logic [RW-1:0]                in_rd_i,
   input  logic [NR-1:0]                in_reg_req_i,
   input  logic                         in_blocking_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [NR-1:0]                locks_i,
   output logic [PW-1:0]                out_payload_o,
   output logic [RW-1:0]                out_rd_o,
   output logic [NR-1:0]                out_reg_req_o,
   output logic                         out_blocking_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

   localparam int OW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   // entry storage; contents beyond occupancy are don't-care
   logic [PW-1:0] payload_q [DEPTH];
   logic [RW-1:0] rd_q      [DEPTH];
   logic [NR-1:0] req_q     [DEPTH];
   logic          blk_q     [DEPTH];
   logic [OW-1:0] occ_q;

   logic [DEPTH-1:0] slot_vld;
   logic [DEPTH-1:0] elig;
   logic [NR-1:0]    foot [DEPTH];
   logic [NR-1:0]    older_foot;
   logic             older_blk;
   logic [IW-1:0]    sel;
   logic             any_elig;
   logic             issue;
   logic             accept;
   logic [IW-1:0]    wr_idx;

   // valid slots form a contiguous prefix of the queue
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         slot_vld[k] = (OW'(k) < occ_q);
      end
   end

   // eligibility: walk from oldest to youngest, accumulating the footprint
   // and barrier status of everything older that is still waiting
   always_comb begin
      older_foot = '0;
      older_blk  = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         foot[k] = req_q[k] | ((rd_q[k] != '0) ? (NR'(1) << rd_q[k]) : '0);
         elig[k] = slot_vld[k]
                 && ((foot[k] & locks_i) == '0)
                 && ((foot[k] & older_foot) == '0)
                 && (!blk_q[k] || (k == 0))
                 && !older_blk;
         if (slot_vld[k]) begin
            older_foot = older_foot | foot[k];
            older_blk  = older_blk | blk_q[k];
         end
      end
   end

   // pick the lowest-index eligible slot
   always_comb begin
      sel      = '0;
      any_elig = 1'b0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (elig[k]) begin
            sel      = IW'(k);
            any_elig = 1'b1;
         end
      end
   end

   // handshakes and outputs; fields are zeroed whenever nothing is offered
   always_comb begin
      out_valid_o    = any_elig && !clear_i;
      in_ready_o     = (occ_q != OW'(DEPTH)) && !clear_i;
      issue          = out_valid_o && out_ready_i;
      accept         = in_valid_i && in_ready_o;
      wr_idx         = IW'(occ_q - OW'(issue));
      occupancy_o    = occ_q;
      out_payload_o  = out_valid_o ? payload_q[sel] : '0;
      out_rd_o       = out_valid_o ? rd_q[sel]      : '0;
      out_reg_req_o  = out_valid_o ? req_q[sel]     : '0;
      out_blocking_o = out_valid_o ? blk_q[sel]     : 1'b0;
   end

   // data path: compact above the issued slot, then append the new entry
   always_ff @(posedge clk_i) begin
      if (issue) begin
         for (int i = 0; i < DEPTH-1; i++) begin
            if (IW'(i) >= sel) begin
               payload_q[i] <= payload_q[i+1];
               rd_q[i]      <= rd_q[i+1];
               req_q[i]     <= req_q[i+1];
               blk_q[i]     <= blk_q[i+1];
            end
         end
      end
      if (accept) begin
         payload_q[wr_idx] <= in_payload_i;
         rd_q[wr_idx]      <= in_rd_i;
         req_q[wr_idx]     <= in_reg_req_i;
         blk_q[wr_idx]     <= in_blocking_i;
      end
   end

   // occupancy: the only control state; flush wins over accept and issue
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         occ_q <= '0;
      end else if (clear_i) begin
         occ_q <= '0;
      end else if (accept && !issue) begin
         occ_q <= occ_q + OW'(1);
      end else if (issue && !accept) begin
         occ_q <= occ_q - OW'(1);
      end
   end

endmodule

// File: tb/tb_maverickone_issue_window.sv
// Bench for maverickone_issue_window: directed vector table, reset sequence,
// then randomized traffic compared against a queue-based reference model.
module tb_maverickone_issue_window;

   localparam int DEPTH = 4;
   localparam int NR    = 32;
   localparam int RW    = 5;
   localparam int PW    = 64;

   logic          clk_i = 1'b0;
   logic          arst_i;
   logic          clear_i;
   logic [PW-1:0] in_payload_i;
   logic [RW-1:0] in_rd_i;
   logic [NR-1:0] in_reg_req_i;
   logic          in_blocking_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [NR-1:0] locks_i;
   logic [PW-1:0] out_payload_o;
   logic [RW-1:0] out_rd_o;
   logic [NR-1:0] out_reg_req_o;
   logic          out_blocking_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [2:0]    occupancy_o;

   maverickone_issue_window #(.DEPTH(DEPTH), .NR(NR), .RW(RW), .PW(PW)) dut (
      .clk_i(clk_i), .arst_i(arst_i), .clear_i(clear_i),
      .in_payload_i(in_payload_i), .in_rd_i(in_rd_i), .in_reg_req_i(in_reg_req_i),
      .in_blocking_i(in_blocking_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .locks_i(locks_i), .out_payload_o(out_payload_o), .out_rd_o(out_rd_o),
      .out_reg_req_o(out_reg_req_o), .out_blocking_o(out_blocking_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .occupancy_o(occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   int nchk = 0;
   int nfail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic [31:0] req;
      logic        blk;
      logic [31:0] lk;
      logic        ordy;
      logic        clr;
      logic        e_ov;
      logic [4:0]  e_rd;
      logic [2:0]  e_occ;
      logic        e_ir;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [31:0] req,
                               input logic blk, input logic [31:0] lk, input logic ordy,
                               input logic clr, input logic e_ov, input logic [4:0] e_rd,
                               input logic [2:0] e_occ, input logic e_ir);
      vec_t r;
      r.v = v; r.rd = rd; r.req = req; r.blk = blk; r.lk = lk; r.ordy = ordy; r.clr = clr;
      r.e_ov = e_ov; r.e_rd = e_rd; r.e_occ = e_occ; r.e_ir = e_ir;
      return r;
   endfunction

   // reference model: plain queue of entries, oldest first
   typedef struct {
      logic [63:0] pl;
      logic [4:0]  rd;
      logic [31:0] req;
      logic        blk;
   } ent_t;
   ent_t mq[$];

   function automatic logic uses(input ent_t e, input int r);
      return e.req[r] || ((r != 0) && (int'(e.rd) == r));
   endfunction

   function automatic int model_sel(input logic [31:0] lk);
      for (int k = 0; k < mq.size(); k++) begin
         logic ok;
         ok = 1'b1;
         if (mq[k].blk && k != 0) ok = 1'b0;
         for (int j = 0; j < k; j++)
            if (mq[j].blk) ok = 1'b0;
         for (int r = 0; r < NR; r++) begin
            if (uses(mq[k], r) && lk[r]) ok = 1'b0;
            for (int j = 0; j < k; j++)
               if (uses(mq[k], r) && uses(mq[j], r)) ok = 1'b0;
         end
         if (ok) return k;
      end
      return -1;
   endfunction

   vec_t tbl[36];

   initial begin
      logic [31:0] L5, LA;
      L5 = 32'h20; LA = 32'hFFFF_FFFF;
      // single enqueue / issue
      tbl[0]  = mk(1, 3, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 3, 1, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0,   1, 3, 1, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      // lock on r5: C bypasses A and B, then A, B in order
      tbl[4]  = mk(1, 5, 0, 0, L5, 0, 0,  0, 0, 0, 1);
      tbl[5]  = mk(1, 0, L5, 0, L5, 0, 0, 0, 0, 1, 1);
      tbl[6]  = mk(1, 7, 0, 0, L5, 0, 0,  0, 0, 2, 1);
      tbl[7]  = mk(0, 0, 0, 0, L5, 1, 0,  1, 7, 3, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0,   1, 5, 2, 1);
      tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 1);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      // fill while everything locked, then issue and stall coincide
      tbl[11] = mk(1, 1, 0, 0, LA, 1, 0,  0, 0, 0, 1);
      tbl[12] = mk(1, 2, 0, 0, LA, 1, 0,  0, 0, 1, 1);
      tbl[13] = mk(1, 3, 0, 0, LA, 1, 0,  0, 0, 2, 1);
      tbl[14] = mk(1, 4, 0, 0, LA, 1, 0,  0, 0, 3, 1);
      tbl[15] = mk(1, 9, 0, 0, LA, 1, 0,  0, 0, 4, 0);
      tbl[16] = mk(1, 9, 0, 0, 0, 1, 0,   1, 1, 4, 0);
      tbl[17] = mk(1, 9, 0, 0, 0, 0, 0,   1, 2, 3, 1);
      tbl[18] = mk(0, 0, 0, 0, 0, 1, 0,   1, 2, 4, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 1, 0,   1, 3, 3, 1);
      tbl[20] = mk(0, 0, 0, 0, 0, 1, 0,   1, 4, 2, 1);
      tbl[21] = mk(0, 0, 0, 0, 0, 1, 0,   1, 9, 1, 1);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
      // blocking X behind locked A, free D behind X
      tbl[23] = mk(1, 5, 0, 0, L5, 1, 0,  0, 0, 0, 1);
      tbl[24] = mk(1, 6, 0, 1, L5, 1, 0,  0, 0, 1, 1);
      tbl[25] = mk(1, 8, 0, 0, L5, 1, 0,  0, 0, 2, 1);
      tbl[26] = mk(0, 0, 0, 0, L5, 1, 0,  0, 0, 3, 1);
      tbl[27] = mk(0, 0, 0, 0, 0, 1, 0,   1, 5, 3, 1);
      tbl[28] = mk(0, 0, 0, 0, 0, 1, 0,   1, 6, 2, 1);
      tbl[29] = mk(0, 0, 0, 0, 0, 1, 0,   1, 8, 1, 1);
      tbl[30] = mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1);
      // flush overrides accept and issue
      tbl[31] = mk(1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 1);
      tbl[32] = mk(1, 11, 0, 0, 0, 0, 0,  1, 10, 1, 1);
      tbl[33] = mk(1, 12, 0, 0, 0, 0, 0,  1, 10, 2, 1);
      tbl[34] = mk(1, 13, 0, 0, 0, 1, 1,  0, 0, 3, 0);
      tbl[35] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);

      arst_i = 1'b1; clear_i = 1'b0; in_payload_i = '0; in_rd_i = '0; in_reg_req_i = '0;
      in_blocking_i = 1'b0; in_valid_i = 1'b0; locks_i = '0; out_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset.occ", occupancy_o, 0);
      check("reset.ov", out_valid_o, 0);
      check("reset.rd", out_rd_o, 0);
      arst_i = 1'b0;
      #1;
      check("reset.ir", in_ready_o, 1);
      @(posedge clk_i); #1;

      // directed vector table
      for (int i = 0; i < 36; i++) begin
         in_valid_i = tbl[i].v; in_rd_i = tbl[i].rd; in_reg_req_i = tbl[i].req;
         in_blocking_i = tbl[i].blk; locks_i = tbl[i].lk; out_ready_i = tbl[i].ordy;
         clear_i = tbl[i].clr; in_payload_i = 64'hC0DE_0000_0000_0000 | 64'(i);
         #1;
         check($sformatf("vec%0d.ov", i), out_valid_o, tbl[i].e_ov);
         check($sformatf("vec%0d.rd", i), out_rd_o, tbl[i].e_rd);
         check($sformatf("vec%0d.occ", i), occupancy_o, tbl[i].e_occ);
         check($sformatf("vec%0d.ir", i), in_ready_o, tbl[i].e_ir);
         @(posedge clk_i); #1;
      end

      // asynchronous reset with three entries held
      in_valid_i = 1'b1; locks_i = '1; out_ready_i = 1'b0; clear_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_rd_i = RW'(i + 1); in_reg_req_i = '0; in_blocking_i = 1'b0;
         @(posedge clk_i); #1;
      end
      in_valid_i = 1'b0;
      check("mid.occ_before", occupancy_o, 3);
      locks_i = '0;
      #1;
      check("mid.ov_before", out_valid_o, 1);
      arst_i = 1'b1;
      #1;
      check("mid.occ_rst", occupancy_o, 0);
      check("mid.ov_rst", out_valid_o, 0);
      check("mid.rd_rst", out_rd_o, 0);
      #1 arst_i = 1'b0;
      @(posedge clk_i); #1;
      check("mid.ir_after", in_ready_o, 1);
      check("mid.occ_after", occupancy_o, 0);

      // randomized traffic against the reference model
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         int   s;
         logic e_ov, e_ir;
         ent_t n;
         in_valid_i    = ($urandom_range(0, 1) == 1);
         in_rd_i       = RW'($urandom_range(0, 7));
         in_reg_req_i  = '0;
         if ($urandom_range(0, 2) != 0) in_reg_req_i[$urandom_range(0, 7)] = 1'b1;
         if ($urandom_range(0, 3) == 0) in_reg_req_i[$urandom_range(0, 7)] = 1'b1;
         in_blocking_i = ($urandom_range(0, 7) == 0);
         in_payload_i  = {$urandom, $urandom};
         locks_i       = '0;
         for (int r = 0; r < 8; r++) locks_i[r] = ($urandom_range(0, 5) == 0);
         out_ready_i   = ($urandom_range(0, 3) != 0);
         clear_i       = ($urandom_range(0, 31) == 0);
         #1;
         s    = model_sel(locks_i);
         e_ov = (s >= 0) && !clear_i;
         e_ir = (mq.size() != DEPTH) && !clear_i;
         check("rnd.ov", out_valid_o, e_ov);
         check("rnd.ir", in_ready_o, e_ir);
         check("rnd.occ", occupancy_o, mq.size());
         check("rnd.rd", out_rd_o, e_ov ? mq[s].rd : 5'd0);
         check("rnd.req", out_reg_req_o, e_ov ? mq[s].req : 32'd0);
         check("rnd.blk", out_blocking_o, e_ov ? mq[s].blk : 1'b0);
         check("rnd.pl", out_payload_o, e_ov ? mq[s].pl : 64'd0);
         if (clear_i) begin
            mq.delete();
         end else begin
            if (e_ov && out_ready_i) mq.delete(s);
            if (in_valid_i && e_ir) begin
               n.pl = in_payload_i; n.rd = in_rd_i; n.req = in_reg_req_i; n.blk = in_blocking_i;
               mq.push_back(n);
            end
         end
         @(posedge clk_i); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
